// File: rtl/io_board_ctrl.sv
// Board I/O stage: scans a latched 32-bit word onto an 8-digit active-low
// seven-segment display and debounces the slide switches for the CPU.
module io_board_ctrl #(
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_to_io,
  input  logic        disp_en,
  input  logic        blank_lz,
  input  logic [15:0] sw_raw,
  output logic [15:0] rdata_from_io,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  // Display path state
  logic [31:0]       disp_q, disp_d;
  logic [SCAN_W-1:0] pres_q, pres_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [7:0]        an_q, an_d;

  // Switch path state
  logic [15:0]       sw_s1_q, sw_s1_d;
  logic [15:0]       sw_s2_q, sw_s2_d;
  logic [15:0]       cand_q, cand_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       rdata_q, rdata_d;

  logic [7:0]        nib_nz;
  logic [2:0]        hi_idx;
  logic [3:0]        cur_nib;
  logic [7:0]        cur_seg;
  logic              blank_digit;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib_nz
      assign nib_nz[gi] = |disp_q[4*gi +: 4];
    end
  endgenerate

  // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 always shows.
  always_comb begin
    hi_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (nib_nz[i]) hi_idx = 3'(i);
    end
  end

  assign cur_nib     = disp_q[{idx_q, 2'b00} +: 4];
  assign blank_digit = blank_lz && (idx_q > hi_idx);

  always_comb begin
    cur_seg = 8'hFF;
    case (cur_nib)
      4'h0: cur_seg = 8'hC0;
      4'h1: cur_seg = 8'hF9;
      4'h2: cur_seg = 8'hA4;
      4'h3: cur_seg = 8'hB0;
      4'h4: cur_seg = 8'h99;
      4'h5: cur_seg = 8'h92;
      4'h6: cur_seg = 8'h82;
      4'h7: cur_seg = 8'hF8;
      4'h8: cur_seg = 8'h80;
      4'h9: cur_seg = 8'h90;
      4'hA: cur_seg = 8'h88;
      4'hB: cur_seg = 8'h83;
      4'hC: cur_seg = 8'hC6;
      4'hD: cur_seg = 8'hA1;
      4'hE: cur_seg = 8'h86;
      4'hF: cur_seg = 8'h8E;
      default: cur_seg = 8'hFF;
    endcase
  end

  always_comb begin
    disp_d = disp_q;
    pres_d = pres_q;
    idx_d  = idx_q;
    seg_d  = 8'hFF;
    an_d   = 8'hFF;

    if (disp_en) disp_d = data_to_io;

    if (pres_q == SCAN_LAST) begin
      pres_d = '0;
      idx_d  = idx_q + 3'd1;
    end else begin
      pres_d = pres_q + SCAN_W'(1);
    end

    // Outputs reflect the pre-edge idx/disp, giving a one-cycle lag.
    if (!blank_digit) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = cur_seg;
    end
  end

  always_comb begin
    sw_s1_d = sw_raw;
    sw_s2_d = sw_s1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    // Any difference restarts the window; a full window saturates and publishes.
    if (sw_s2_q != cand_q) begin
      cand_d = sw_s2_q;
      cnt_d  = '0;
    end else if (cnt_q == DEB_LAST) begin
      rdata_d = cand_q;
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= '0;
      pres_q  <= '0;
      idx_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= 8'hFF;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      disp_q  <= disp_d;
      pres_q  <= pres_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_from_io = rdata_q;
  assign seg_n         = seg_q;
  assign an_n          = an_q;

endmodule
